// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_pg_cla.sv
// One 4-bit propagate/generate adder slice with lookahead carry chain.
module pg_cla_nibble
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Carries are built in one process so the chain is evaluated in order.
  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < NIBBLE_W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s  = p ^ c[NIBBLE_W-1:0];
  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one shared 4-bit CLA slice processes one nibble per RUN cycle.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                    cin,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                    cout,
  output logic                    busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_co;

  assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  pg_cla_nibble u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_s;
        carry_d = nib_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          cout_d  = nib_co;
          state_d = DONE;
        end
      end
      DONE: begin
        // New requests are not looked at here, even on the release edge.
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign sum         = sum_q;
  assign cout        = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: directed operations, decoupled result monitor.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    int           acc;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[7] = '{
    '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1},
    '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0},
    '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1},
    '{16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0},
    '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0}
  };

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
  endtask

  // Offer one operation; optionally record its expected result when accepted.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                       input bit push, input logic [W-1:0] es, input logic ec);
    int n;
    @(negedge clk);
    a = av;
    b = bv;
    cin = ci;
    start_valid = 1'b1;
    n = 0;
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) begin
      fail_now("accept");
      start_valid = 1'b0;
      return;
    end
    if (push) q.push_back('{es, ec, cyc + 1});
    $display("issue a=0x%04h b=0x%04h cin=%0d expect sum=0x%04h cout=%0d", av, bv, ci, es, ec);
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy || q.size() != 0) fail_now("drain");
  endtask

  // Monitor: latency on res_valid rise, value check on each result handshake.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (res_valid && !prev) begin
          if (q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_result: got sum=0x%04h cout=%0d with nothing outstanding", sum, cout);
          end else begin
            check("latency", 32'(cyc - q[0].acc), 32'(NIBBLES));
          end
        end
        if (res_valid && res_ready && q.size() > 0) begin
          e = q.pop_front();
          $display("result sum=0x%04h cout=%0d expected sum=0x%04h cout=%0d", sum, cout, e.s, e.co);
          check("sum", 32'(sum), 32'(e.s));
          check("cout", 32'(cout), 32'(e.co));
        end
        prev = res_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].ci, 1'b1, vecs[i].s, vecs[i].co);
    end
    wait_idle();

    // Operands change right after acceptance; the latched copy must be used.
    do_op(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0);
    a = '1;
    b = '1;
    cin = 1'b1;
    wait_idle();

    // Backpressure: hold the result while a competing request is offered.
    res_ready = 1'b0;
    do_op(16'h9000, 16'h8000, 1'b0, 1'b1, 16'h1000, 1'b1);
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) fail_now("bp_wait");
    start_valid = 1'b1;
    a = 16'h1111;
    b = 16'h1111;
    cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h1000);
      check("bp_cout", 32'(cout), 32'd1);
      check("bp_start_ready", 32'(start_ready), 32'd0);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    @(negedge clk);
    check("bp_no_accept_busy", 32'(busy), 32'd0);
    check("bp_idle_ready", 32'(start_ready), 32'd1);
    wait_idle();

    // Reset two RUN cycles into an operation: nothing may come out.
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_start_ready", 32'(start_ready), 32'd1);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1);
    wait_idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit passes; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start_valid, input, 1, requester offers an operation.
REQ-005 The block SHALL have port start_ready, output, 1, block accepts an operation.
REQ-006 The block SHALL have ports a and b, input, W each, addend operands.
REQ-007 The block SHALL have port cin, input, 1, carry-in.
REQ-008 The block SHALL have port res_valid, output, 1, result available.
REQ-009 The block SHALL have port res_ready, input, 1, consumer takes the result.
REQ-010 The block SHALL have port sum, output, W, registered result.
REQ-011 The block SHALL have port cout, output, 1, registered carry-out.
REQ-012 The block SHALL have port busy, output, 1, high in RUN or DONE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 start_ready SHALL be 1 only in IDLE; res_valid SHALL be 1 only in DONE.
REQ-015 Acceptance SHALL occur on an edge where start_valid && start_ready, latching a, b, and cin into the carry register, clearing nibble index idx to 0, clearing sum, and moving to RUN.
REQ-016 Each RUN cycle SHALL use one 4-bit slice to process nibble idx: p = a_n^b_n, g = a_n&b_n, internal carries c0=carry, c(i+1)=g_i|(p_i&c_i), s = p^c[3:0].
REQ-017 Each RUN cycle SHALL write s into sum[4*idx+3:4*idx], load c4 into the carry register, and increment idx.
REQ-018 When idx = NIBBLES-1, the RUN cycle SHALL complete the final nibble, load cout from c4, and move to DONE.
REQ-019 res_valid SHALL rise exactly NIBBLES edges after the accepting edge, giving latency 4 for the default.
REQ-020 In DONE, sum and cout SHALL hold stable until res_ready is 1; an edge with res_ready=1 SHALL return the FSM to IDLE.
REQ-021 start_valid SHALL be ignored in RUN and DONE, including the DONE edge on which res_ready=1; the next acceptance SHALL occur in IDLE at the earliest.
REQ-022 The minimum issue interval SHALL be NIBBLES+2 cycles.
REQ-023 Changes on a, b, or cin after acceptance SHALL NOT affect the result.
REQ-024 The result SHALL be modulo 2^W, with the overflow carry on cout; the all-ones plus carry-in case SHALL wrap to 0 with cout=1.

Reset
REQ-025 Assertion of rst_n=0 SHALL immediately force IDLE, idx=0, carry=0, sum=0, cout=0, res_valid=0, busy=0 and start_ready=1, asynchronously and regardless of state.
REQ-026 Reset asserted during RUN or DONE SHALL discard the operation with no result produced.
REQ-027 Deassertion of reset SHALL be synchronous to clk; the first acceptance SHALL be possible on the first edge after deassertion.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration (2-bit encoding) and the nibble width constant 4.
REQ-029 The 4-bit propagate/generate plus lookahead-carry logic SHALL be one sub-module, pg_cla_nibble, with inputs a[3:0], b[3:0], ci and outputs s[3:0], co.
REQ-030 The controller SHALL instantiate pg_cla_nibble exactly once and time-multiplex it across nibbles.

Verification
REQ-031 Basic add: accept a=0x1234, b=0x4321, cin=0 -> res_valid 4 edges later, sum=0x5555, cout=0.
REQ-032 Carry ripple across nibbles: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; and a=0x0FFF, b=0x0001 -> sum=0x1000, cout=0.
REQ-033 Carry-in: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; a=0x00FF, b=0x0F00, cin=1 -> sum=0x1000.
REQ-034 Backpressure: hold res_ready=0 for 3 cycles in DONE -> res_valid, sum, and cout stable; start_ready=0; a concurrent start_valid is not accepted.
REQ-035 Operand isolation: after accepting 0x0001+0x0001, drive a=b=0xFFFF during RUN -> sum=0x0002.
REQ-036 Reset mid-RUN: assert rst_n=0 after 2 RUN cycles -> all outputs 0 (start_ready=1) immediately, no res_valid; the following op 0x8000+0x8000 -> sum=0x0000, cout=1.
